// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the accumulator-CPU pipeline sequencer: opcode map,
// accumulator masks and sequencer state encoding.
package pipe_ctrl_pkg;

  localparam int OPW_DEF = 6;

  localparam logic [OPW_DEF-1:0] OP_NOP   = 6'h00;
  localparam logic [OPW_DEF-1:0] OP_LDA   = 6'h01;
  localparam logic [OPW_DEF-1:0] OP_LDB   = 6'h02;
  localparam logic [OPW_DEF-1:0] OP_LDCA  = 6'h03;
  localparam logic [OPW_DEF-1:0] OP_LDCB  = 6'h04;
  localparam logic [OPW_DEF-1:0] OP_STA   = 6'h05;
  localparam logic [OPW_DEF-1:0] OP_STB   = 6'h06;
  localparam logic [OPW_DEF-1:0] OP_ADDA  = 6'h08;
  localparam logic [OPW_DEF-1:0] OP_SUBA  = 6'h09;
  localparam logic [OPW_DEF-1:0] OP_ANDA  = 6'h0A;
  localparam logic [OPW_DEF-1:0] OP_ORA   = 6'h0B;
  localparam logic [OPW_DEF-1:0] OP_ASLA  = 6'h0C;
  localparam logic [OPW_DEF-1:0] OP_ASRA  = 6'h0D;
  localparam logic [OPW_DEF-1:0] OP_ADDB  = 6'h10;
  localparam logic [OPW_DEF-1:0] OP_SUBB  = 6'h11;
  localparam logic [OPW_DEF-1:0] OP_ANDB  = 6'h12;
  localparam logic [OPW_DEF-1:0] OP_ORB   = 6'h13;
  localparam logic [OPW_DEF-1:0] OP_ASLB  = 6'h14;
  localparam logic [OPW_DEF-1:0] OP_ASRB  = 6'h15;
  localparam logic [OPW_DEF-1:0] OP_ADDCA = 6'h18;
  localparam logic [OPW_DEF-1:0] OP_SUBCA = 6'h19;
  localparam logic [OPW_DEF-1:0] OP_ANDCA = 6'h1A;
  localparam logic [OPW_DEF-1:0] OP_ORCA  = 6'h1B;
  localparam logic [OPW_DEF-1:0] OP_ADDCB = 6'h1C;
  localparam logic [OPW_DEF-1:0] OP_SUBCB = 6'h1D;
  localparam logic [OPW_DEF-1:0] OP_ANDCB = 6'h1E;
  localparam logic [OPW_DEF-1:0] OP_ORCB  = 6'h1F;
  localparam logic [OPW_DEF-1:0] OP_BAEQ  = 6'h20;
  localparam logic [OPW_DEF-1:0] OP_BAGT  = 6'h21;
  localparam logic [OPW_DEF-1:0] OP_BALT  = 6'h22;
  localparam logic [OPW_DEF-1:0] OP_BBEQ  = 6'h24;
  localparam logic [OPW_DEF-1:0] OP_BBGT  = 6'h25;
  localparam logic [OPW_DEF-1:0] OP_BBLT  = 6'h26;
  localparam logic [OPW_DEF-1:0] OP_JMP   = 6'h28;

  // Accumulator masks: bit0 = A, bit1 = B.
  localparam logic [1:0] ACC_NONE = 2'b00;
  localparam logic [1:0] ACC_A    = 2'b01;
  localparam logic [1:0] ACC_B    = 2'b10;
  localparam logic [1:0] ACC_AB   = 2'b11;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_FAULT    = 2'd2
  } ctl_state_t;

endpackage

// File: rtl/pipe_ctrl_opcode_class.sv
// Opcode classifier: which accumulators an instruction reads and writes,
// and whether it touches data memory or redirects the PC.
module pipe_ctrl_opcode_class
  import pipe_ctrl_pkg::*;
#(
  parameter int OPW = 6
) (
  input  logic [OPW-1:0] opcode_i,
  output logic [1:0]     src_mask_o,
  output logic [1:0]     dst_mask_o,
  output logic           is_mem_o,
  output logic           is_branch_o
);

  always_comb begin
    src_mask_o  = ACC_NONE;
    dst_mask_o  = ACC_NONE;
    is_mem_o    = 1'b0;
    is_branch_o = 1'b0;
    case (opcode_i)
      OP_LDA:  begin dst_mask_o = ACC_A; is_mem_o = 1'b1; end
      OP_LDB:  begin dst_mask_o = ACC_B; is_mem_o = 1'b1; end
      OP_LDCA: dst_mask_o = ACC_A;
      OP_LDCB: dst_mask_o = ACC_B;
      OP_STA:  begin src_mask_o = ACC_A; is_mem_o = 1'b1; end
      OP_STB:  begin src_mask_o = ACC_B; is_mem_o = 1'b1; end
      OP_ADDA, OP_SUBA, OP_ANDA, OP_ORA: begin
        src_mask_o = ACC_AB; dst_mask_o = ACC_A;
      end
      OP_ASLA, OP_ASRA, OP_ADDCA, OP_SUBCA, OP_ANDCA, OP_ORCA: begin
        src_mask_o = ACC_A; dst_mask_o = ACC_A;
      end
      OP_ADDB, OP_SUBB, OP_ANDB, OP_ORB: begin
        src_mask_o = ACC_AB; dst_mask_o = ACC_B;
      end
      OP_ASLB, OP_ASRB, OP_ADDCB, OP_SUBCB, OP_ANDCB, OP_ORCB: begin
        src_mask_o = ACC_B; dst_mask_o = ACC_B;
      end
      OP_BAEQ, OP_BAGT, OP_BALT: begin src_mask_o = ACC_A; is_branch_o = 1'b1; end
      OP_BBEQ, OP_BBGT, OP_BBLT: begin src_mask_o = ACC_B; is_branch_o = 1'b1; end
      OP_JMP:  is_branch_o = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: stalls on accumulator RAW hazards, flushes on taken
// branches and freezes the whole pipe while data memory is busy.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int OPW         = 6,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNTW        = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [OPW-1:0]  idOpcode,
  input  logic            idValid,
  input  logic            exTakeBranch,
  input  logic            memAck,
  output logic            pcWrite,
  output logic            pcSel,
  output logic            ifIdWrite,
  output logic            ifIdFlush,
  output logic            idExWrite,
  output logic            idExBubble,
  output logic            exMemWrite,
  output logic            memWbWrite,
  output logic            memReq,
  output logic            fault,
  output logic [CNTW-1:0] stallCycles
);

  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  logic [1:0]      id_src, id_dst, ex_dst;
  logic            id_is_mem, id_is_branch, ex_is_mem, ex_is_branch;
  logic [OPW-1:0]  ex_opcode_q;
  logic            ex_valid_q, mem_valid_q, mem_is_mem_q;
  logic [1:0]      mem_dst_q;
  ctl_state_t      state_q;
  logic [7:0]      wait_cnt_q;
  logic [CNTW-1:0] stall_cnt_q, stall_cnt_d;
  logic            hazard, mem_busy, advance;
  logic            unused_class;

  pipe_ctrl_opcode_class #(.OPW(OPW)) u_id_class (
    .opcode_i    (idOpcode),
    .src_mask_o  (id_src),
    .dst_mask_o  (id_dst),
    .is_mem_o    (id_is_mem),
    .is_branch_o (id_is_branch)
  );

  pipe_ctrl_opcode_class #(.OPW(OPW)) u_ex_class (
    .opcode_i    (ex_opcode_q),
    .src_mask_o  (),
    .dst_mask_o  (ex_dst),
    .is_mem_o    (ex_is_mem),
    .is_branch_o (ex_is_branch)
  );

  assign unused_class = ^{id_dst, id_is_mem, id_is_branch, ex_is_branch};

  // WB writes in the first half-cycle, so only EX and MEM producers matter.
  assign hazard   = idValid & |(id_src & ((ex_valid_q  ? ex_dst    : ACC_NONE) |
                                          (mem_valid_q ? mem_dst_q : ACC_NONE)));
  assign mem_busy = mem_valid_q & mem_is_mem_q;

  always_comb begin
    pcWrite    = 1'b0;
    pcSel      = 1'b0;
    ifIdWrite  = 1'b0;
    ifIdFlush  = 1'b0;
    idExWrite  = 1'b0;
    idExBubble = 1'b0;
    exMemWrite = 1'b0;
    memWbWrite = 1'b0;
    memReq     = 1'b0;
    fault      = 1'b0;
    advance    = 1'b0;
    case (state_q)
      ST_RUN: begin
        memReq  = mem_busy;
        advance = ~mem_busy | memAck;
      end
      ST_MEM_WAIT: begin
        memReq  = 1'b1;
        advance = memAck;
      end
      ST_FAULT: fault = 1'b1;
      default: ;
    endcase
    if (advance && rst_n) begin
      exMemWrite = 1'b1;
      memWbWrite = 1'b1;
      idExWrite  = 1'b1;
      if (exTakeBranch) begin
        pcWrite    = 1'b1;
        pcSel      = 1'b1;
        ifIdWrite  = 1'b1;
        ifIdFlush  = 1'b1;
        idExBubble = 1'b1;
      end else if (hazard) begin
        idExBubble = 1'b1;
      end else begin
        pcWrite   = 1'b1;
        ifIdWrite = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_RUN;
      wait_cnt_q <= 8'd0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (mem_busy && !memAck) begin
            state_q    <= ST_MEM_WAIT;
            wait_cnt_q <= 8'd0;
          end
        end
        ST_MEM_WAIT: begin
          wait_cnt_q <= wait_cnt_q + 8'd1;
          if (memAck) begin
            state_q <= ST_RUN;
          end else if (wait_cnt_q == WAIT_LAST) begin
            state_q <= ST_FAULT;
          end
        end
        default: state_q <= ST_FAULT;
      endcase
    end
  end

  // Shadow of the EX and MEM entries, moving only with the real pipe registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_opcode_q  <= '0;
      ex_valid_q   <= 1'b0;
      mem_dst_q    <= ACC_NONE;
      mem_valid_q  <= 1'b0;
      mem_is_mem_q <= 1'b0;
    end else begin
      if (idExWrite) begin
        ex_opcode_q <= idOpcode;
        ex_valid_q  <= idValid & ~idExBubble;
      end
      if (exMemWrite) begin
        mem_dst_q    <= ex_valid_q ? ex_dst : ACC_NONE;
        mem_valid_q  <= ex_valid_q;
        mem_is_mem_q <= ex_valid_q & ex_is_mem;
      end
    end
  end

  assign stall_cnt_d = (!pcWrite && stall_cnt_q != '1) ? stall_cnt_q + CNTW'(1) : stall_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stallCycles = stall_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: hazard stall, memory freeze, branch flush,
// timeout fault, counter saturation and asynchronous reset.
module tb_pipe_ctrl;
  import pipe_ctrl_pkg::*;

  // ctl = {pcWrite,pcSel,ifIdWrite,ifIdFlush,idExWrite,idExBubble,exMemWrite,memWbWrite,memReq,fault}
  localparam logic [9:0] CTL_RESET  = 10'b0000000000;
  localparam logic [9:0] CTL_NORMAL = 10'b1010101100;
  localparam logic [9:0] CTL_HAZARD = 10'b0000111100;
  localparam logic [9:0] CTL_BRANCH = 10'b1111111100;
  localparam logic [9:0] CTL_FREEZE = 10'b0000000010;
  localparam logic [9:0] CTL_ACKADV = 10'b1010101110;
  localparam logic [9:0] CTL_FAULT  = 10'b0000000001;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [5:0]  idOpcode = OP_NOP;
  logic        idValid = 1'b0;
  logic        exTakeBranch = 1'b0;
  logic        memAck = 1'b0;
  logic        pcWrite, pcSel, ifIdWrite, ifIdFlush, idExWrite, idExBubble;
  logic        exMemWrite, memWbWrite, memReq, fault;
  logic [15:0] stallCycles;
  logic [9:0]  ctl;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  pipe_ctrl #(.OPW(6), .MEM_TIMEOUT(4), .CNTW(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .idOpcode     (idOpcode),
    .idValid      (idValid),
    .exTakeBranch (exTakeBranch),
    .memAck       (memAck),
    .pcWrite      (pcWrite),
    .pcSel        (pcSel),
    .ifIdWrite    (ifIdWrite),
    .ifIdFlush    (ifIdFlush),
    .idExWrite    (idExWrite),
    .idExBubble   (idExBubble),
    .exMemWrite   (exMemWrite),
    .memWbWrite   (memWbWrite),
    .memReq       (memReq),
    .fault        (fault),
    .stallCycles  (stallCycles)
  );

  assign ctl = {pcWrite, pcSel, ifIdWrite, ifIdFlush, idExWrite, idExBubble,
                exMemWrite, memWbWrite, memReq, fault};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      n_pass++;
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  // Present one cycle of ID/EX/MEM inputs mid-cycle and let combinational outputs settle.
  task automatic step(input logic [5:0] op, input logic v, input logic br, input logic ack);
    @(negedge clk);
    idOpcode     = op;
    idValid      = v;
    exTakeBranch = br;
    memAck       = ack;
    #1;
  endtask

  task automatic idle();
    step(OP_NOP, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    #1;
    check_eq("reset_ctl", 32'(ctl), 32'(CTL_RESET));
    check_eq("reset_stall", 32'(stallCycles), 32'd0);

    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("first_cycle_ctl", 32'(ctl), 32'(CTL_NORMAL));

    // RAW hazard with producer in EX: two-cycle stall
    step(OP_LDCA, 1'b1, 1'b0, 1'b0);
    check_eq("ldca_ctl", 32'(ctl), 32'(CTL_NORMAL));
    step(OP_ADDCA, 1'b1, 1'b0, 1'b0);
    check_eq("haz_ex_ctl", 32'(ctl), 32'(CTL_HAZARD));
    step(OP_ADDCA, 1'b1, 1'b0, 1'b0);
    check_eq("haz_mem_ctl", 32'(ctl), 32'(CTL_HAZARD));
    step(OP_ADDCA, 1'b1, 1'b0, 1'b0);
    check_eq("haz_release_ctl", 32'(ctl), 32'(CTL_NORMAL));
    check_eq("haz_stall_cnt", 32'(stallCycles), 32'd2);
    repeat (3) idle();

    // LDA with memAck arriving on the fourth request cycle
    step(OP_LDA, 1'b1, 1'b0, 1'b0);
    check_eq("lda_id_ctl", 32'(ctl), 32'(CTL_NORMAL));
    idle();
    check_eq("lda_ex_ctl", 32'(ctl), 32'(CTL_NORMAL));
    for (int i = 0; i < 3; i++) begin
      idle();
      check_eq($sformatf("mem_freeze%0d", i), 32'(ctl), 32'(CTL_FREEZE));
    end
    step(OP_NOP, 1'b0, 1'b0, 1'b1);
    check_eq("mem_ack_ctl", 32'(ctl), 32'(CTL_ACKADV));
    check_eq("mem_stall_cnt", 32'(stallCycles), 32'd5);
    idle();
    check_eq("mem_after_ctl", 32'(ctl), 32'(CTL_NORMAL));

    // Taken branch in EX overrides a hazarding ADDA in ID
    step(OP_LDCB, 1'b1, 1'b0, 1'b0);
    step(OP_BAEQ, 1'b1, 1'b0, 1'b0);
    check_eq("baeq_id_ctl", 32'(ctl), 32'(CTL_NORMAL));
    step(OP_ADDA, 1'b1, 1'b1, 1'b0);
    check_eq("branch_ctl", 32'(ctl), 32'(CTL_BRANCH));
    idle();
    check_eq("branch_after_ctl", 32'(ctl), 32'(CTL_NORMAL));
    check_eq("branch_stall_cnt", 32'(stallCycles), 32'd5);

    // Producer already in MEM: one-cycle stall
    step(OP_LDCB, 1'b1, 1'b0, 1'b0);
    idle();
    step(OP_ADDB, 1'b1, 1'b0, 1'b0);
    check_eq("haz_mem_only_ctl", 32'(ctl), 32'(CTL_HAZARD));
    step(OP_ADDB, 1'b1, 1'b0, 1'b0);
    check_eq("haz_mem_only_rel", 32'(ctl), 32'(CTL_NORMAL));
    check_eq("haz_mem_only_cnt", 32'(stallCycles), 32'd6);

    // Store that is never acknowledged: RUN freeze plus 4 MEM_WAIT cycles, then FAULT
    step(OP_STA, 1'b1, 1'b0, 1'b0);
    check_eq("sta_id_ctl", 32'(ctl), 32'(CTL_NORMAL));
    idle();
    for (int i = 0; i < 5; i++) begin
      idle();
      check_eq($sformatf("to_freeze%0d", i), 32'(ctl), 32'(CTL_FREEZE));
    end
    idle();
    check_eq("fault_ctl", 32'(ctl), 32'(CTL_FAULT));
    check_eq("fault_stall_cnt", 32'(stallCycles), 32'd11);
    step(OP_NOP, 1'b0, 1'b0, 1'b1);
    check_eq("fault_sticky_ctl", 32'(ctl), 32'(CTL_FAULT));

    // FAULT stalls every cycle: walk the counter up to 0xFFFE, then saturate
    repeat (65522) idle();
    check_eq("stall_cnt_fffe", 32'(stallCycles), 32'hFFFE);
    repeat (5) idle();
    check_eq("stall_cnt_sat", 32'(stallCycles), 32'hFFFF);

    #2 rst_n = 1'b0;
    #1;
    check_eq("fault_reset_ctl", 32'(ctl), 32'(CTL_RESET));
    check_eq("fault_reset_cnt", 32'(stallCycles), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("rerun_ctl", 32'(ctl), 32'(CTL_NORMAL));

    // Asynchronous reset in the middle of MEM_WAIT
    step(OP_LDB, 1'b1, 1'b0, 1'b0);
    idle();
    idle();
    check_eq("ldb_req_ctl", 32'(ctl), 32'(CTL_FREEZE));
    idle();
    check_eq("ldb_wait_ctl", 32'(ctl), 32'(CTL_FREEZE));
    #2 rst_n = 1'b0;
    #1;
    check_eq("wait_reset_ctl", 32'(ctl), 32'(CTL_RESET));
    check_eq("wait_reset_cnt", 32'(stallCycles), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("wait_rerun_ctl", 32'(ctl), 32'(CTL_NORMAL));
    idle();
    check_eq("wait_rerun_cnt", 32'(stallCycles), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
